// File: rtl/spi_dac_pkg.sv
// Shared types and helpers for the SPI DAC scheduler.
// Holds the FSM state enum, frame width and frame packing.
package spi_dac_pkg;

  localparam int FRAME_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    START   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4,
    GAP     = 3'd5
  } sched_state_t;

  // Frame is {zero pad, data, cfg}; callers zero-extend data/cfg.
  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic [FRAME_W-1:0] data,
    input logic [FRAME_W-1:0] cfg,
    input int unsigned        cfg_w
  );
    return (data << cfg_w) | cfg;
  endfunction

endpackage

// File: rtl/spi_dac_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr+1, wraps.
// Ports: req, ptr in; gnt (one-hot), idx, any out.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IW-1:0]     idx,
  output logic              any
);

  always_comb begin
    logic          found;
    logic [IW-1:0] ci;
    int            c;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    ci    = '0;
    c     = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      c  = (int'(ptr) + k) % NUM_CH;
      ci = IW'(c);
      if (!found && req[ci]) begin
        found   = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/spi_dac_scheduler.sv
// Round-robin scheduler of per-channel DAC writes onto one SPI serializer.
// Ports: clk, rst (sync, high); ch_valid/ch_ready/ch_data/ch_cfg per
// channel; spi_start/spi_word/spi_busy to the serializer; grant_ch,
// sched_busy, timeout_err status. Macro SPI_DAC_SCHED_COALESCE_EN makes
// ch_ready constant 1 and lets a new write overwrite a pending value.
module spi_dac_scheduler
  import spi_dac_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 8,
  parameter int CFG_W   = 4,
  parameter int GAP_CYC = 4,
  parameter int BUSY_TO = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_valid,
  output logic [NUM_CH-1:0]          ch_ready,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  input  logic [NUM_CH*CFG_W-1:0]    ch_cfg,
  output logic                       spi_start,
  output logic [FRAME_W-1:0]         spi_word,
  input  logic                       spi_busy,
  output logic [$clog2(NUM_CH)-1:0]  grant_ch,
  output logic                       sched_busy,
  output logic                       timeout_err
);

  localparam int IW   = $clog2(NUM_CH);
  localparam int CMAX = (BUSY_TO > GAP_CYC) ? BUSY_TO : GAP_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  sched_state_t state, state_d;

  logic [CW-1:0]     cnt, cnt_d;
  logic [NUM_CH-1:0] pending, pending_d;
  logic [NUM_CH-1:0] we;
  logic [DATA_W-1:0] data_q [NUM_CH];
  logic [CFG_W-1:0]  cfg_q  [NUM_CH];
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     grant_q;
  logic [FRAME_W-1:0] word_q;
  logic              err_q;
  logic              arb_load;
  logic              set_err;

  logic [NUM_CH-1:0] arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_arb (
    .req (pending),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

`ifdef SPI_DAC_SCHED_COALESCE_EN
  assign ch_ready = '1;
`else
  assign ch_ready = ~pending;
`endif

  assign we = ch_valid & ch_ready;

  // A write landing with its own grant keeps pending set:
  // the frame takes the old value, the new one waits.
  always_comb begin
    pending_d = pending;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_load && arb_gnt[i]) pending_d[i] = 1'b0;
      if (we[i])                  pending_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    arb_load = 1'b0;
    set_err  = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_any) state_d = ARB;
      end
      ARB: begin
        arb_load = 1'b1;
        state_d  = START;
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (spi_busy) begin
          state_d = WAIT_LO;
        end else if (cnt == CW'(BUSY_TO - 1)) begin
          set_err = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      WAIT_LO: begin
        if (!spi_busy) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYC - 1)) state_d = IDLE;
        else                         cnt_d = cnt + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      pending <= '0;
      ptr     <= IW'(NUM_CH - 1);
      grant_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        data_q[i] <= '0;
        cfg_q[i]  <= '0;
      end
    end else begin
      cnt     <= cnt_d;
      pending <= pending_d;
      if (set_err) err_q <= 1'b1;
      if (arb_load) begin
        ptr     <= arb_idx;
        grant_q <= arb_idx;
        word_q  <= pack_frame(FRAME_W'(data_q[arb_idx]),
                              FRAME_W'(cfg_q[arb_idx]), CFG_W);
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (we[i]) begin
          data_q[i] <= ch_data[i*DATA_W +: DATA_W];
          cfg_q[i]  <= ch_cfg[i*CFG_W +: CFG_W];
        end
      end
    end
  end

  assign spi_start   = (state == START);
  assign spi_word    = word_q;
  assign grant_ch    = grant_q;
  assign sched_busy  = (state != IDLE);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_spi_dac_scheduler.sv
// Directed bench for spi_dac_scheduler with a simple busy model.
// Covers latency, fairness, timeout, mid-frame reset, write merging.
module tb_spi_dac_scheduler;

`ifdef SPI_DAC_SCHED_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ch_valid;
  logic [3:0]  ch_ready;
  logic [31:0] ch_data;
  logic [15:0] ch_cfg;
  logic        spi_start;
  logic [15:0] spi_word;
  logic        spi_busy;
  logic [1:0]  grant_ch;
  logic        sched_busy;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int busy_len = 0;
  int bcnt   = 0;
  int n0, t0;

  int         st_cyc [$];
  logic [1:0] st_ch  [$];
  logic [15:0] st_word [$];

  spi_dac_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .ch_valid    (ch_valid),
    .ch_ready    (ch_ready),
    .ch_data     (ch_data),
    .ch_cfg      (ch_cfg),
    .spi_start   (spi_start),
    .spi_word    (spi_word),
    .spi_busy    (spi_busy),
    .grant_ch    (grant_ch),
    .sched_busy  (sched_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Serializer model: busy rises the cycle after start, for busy_len.
  always @(posedge clk) begin
    if (rst)                           bcnt <= 0;
    else if (bcnt > 0)                 bcnt <= bcnt - 1;
    else if (spi_start && busy_len > 0) bcnt <= busy_len;
  end
  assign spi_busy = (bcnt > 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (spi_start) begin
      st_cyc.push_back(cyc);
      st_ch.push_back(grant_ch);
      st_word.push_back(spi_word);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int ch, input logic [7:0] d,
                    input logic [3:0] c);
    ch_data[ch*8 +: 8] = d;
    ch_cfg[ch*4 +: 4]  = c;
    ch_valid[ch]       = 1'b1;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!spi_start && n < 60) begin
      step();
      n++;
    end
    chk("start_timeout", 32'(n < 60), 32'd1);
  endtask

  task automatic wait_idle();
    int q = 0;
    int n = 0;
    while (q < 3 && n < 600) begin
      step();
      n++;
      if (!sched_busy) q++;
      else             q = 0;
    end
    chk("idle_timeout", 32'(n < 600), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(ch_ready), 32'hF);
    chk({tag, "_start"}, 32'(spi_start), 32'd0);
    chk({tag, "_word"}, 32'(spi_word), 32'd0);
    chk({tag, "_grant"}, 32'(grant_ch), 32'd0);
    chk({tag, "_sbusy"}, 32'(sched_busy), 32'd0);
    chk({tag, "_terr"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    ch_valid = '0;
    ch_data  = '0;
    ch_cfg   = '0;
    step();
    step();
    chk_reset_vals("rst");
    rst = 1'b0;
    step();

    // Single write ch2: start three cycles after presenting it.
    busy_len = 3;
    wr(2, 8'd120, 4'hC);
    step();
    ch_valid = '0;
    chk("t1_rdy_acc", 32'(ch_ready[2]), 32'(COAL));
    chk("t1_start_early", 32'(spi_start), 32'd0);
    step();
    chk("t1_rdy_arb", 32'(ch_ready[2]), 32'(COAL));
    chk("t1_sbusy_arb", 32'(sched_busy), 32'd1);
    step();
    chk("t1_start", 32'(spi_start), 32'd1);
    chk("t1_word", 32'(spi_word), 32'h078C);
    chk("t1_grant", 32'(grant_ch), 32'd2);
    chk("t1_rdy_after", 32'(ch_ready[2]), 32'd1);
    step();
    chk("t1_pulse_1cyc", 32'(spi_start), 32'd0);
    wait_idle();

    // All four channels at once: fair order and frame spacing.
    pulse_rst();
    busy_len = 20;
    st_cyc.delete();
    st_ch.delete();
    st_word.delete();
    wr(0, 8'h11, 4'h0);
    wr(1, 8'h22, 4'h1);
    wr(2, 8'h33, 4'h2);
    wr(3, 8'h44, 4'h3);
    step();
    ch_valid = '0;
    n0 = 0;
    while (st_ch.size() < 4 && n0 < 400) begin
      step();
      n0++;
    end
    chk("t2_frames", 32'(st_ch.size()), 32'd4);
    if (st_ch.size() >= 4) begin
      chk("t2_g0", 32'(st_ch[0]), 32'd0);
      chk("t2_g1", 32'(st_ch[1]), 32'd1);
      chk("t2_g2", 32'(st_ch[2]), 32'd2);
      chk("t2_g3", 32'(st_ch[3]), 32'd3);
      chk("t2_w0", 32'(st_word[0]), 32'h0110);
      chk("t2_w3", 32'(st_word[3]), 32'h0443);
      for (int k = 0; k < 3; k++)
        chk("t2_spacing", 32'(st_cyc[k+1] - st_cyc[k]), 32'd28);
    end
    wait_idle();

    // ch1 and ch3 held valid: grants alternate.
    busy_len = 2;
    st_ch.delete();
    st_word.delete();
    wr(1, 8'hA1, 4'h1);
    wr(3, 8'hB3, 4'h3);
    n0 = 0;
    while (st_ch.size() < 6 && n0 < 400) begin
      step();
      n0++;
    end
    ch_valid = '0;
    chk("t3_frames", 32'(st_ch.size() >= 6), 32'd1);
    if (st_ch.size() >= 6) begin
      for (int k = 0; k < 6; k++)
        chk("t3_alt", 32'(st_ch[k]), (k % 2 == 0) ? 32'd1 : 32'd3);
      chk("t3_w0", 32'(st_word[0]), 32'h0A11);
      chk("t3_w1", 32'(st_word[1]), 32'h0B33);
    end
    wait_idle();

    // Busy never rises: timeout, then the next request still runs.
    pulse_rst();
    busy_len = 0;
    wr(0, 8'h5A, 4'h6);
    wr(2, 8'h3C, 4'h9);
    step();
    ch_valid = '0;
    wait_start();
    chk("t4_g0", 32'(grant_ch), 32'd0);
    repeat (15) step();
    chk("t4_err_early", 32'(timeout_err), 32'd0);
    repeat (2) step();
    chk("t4_err_set", 32'(timeout_err), 32'd1);
    chk("t4_in_gap", 32'(sched_busy), 32'd1);
    repeat (6) step();
    chk("t4_next_start", 32'(spi_start), 32'd1);
    chk("t4_next_grant", 32'(grant_ch), 32'd2);
    chk("t4_next_word", 32'(spi_word), 32'h03C9);
    wait_idle();
    chk("t4_err_sticky", 32'(timeout_err), 32'd1);

    // Reset mid-frame with two channels still pending.
    pulse_rst();
    chk("t5_err_clr", 32'(timeout_err), 32'd0);
    busy_len = 30;
    wr(0, 8'h01, 4'h1);
    wr(1, 8'h02, 4'h2);
    wr(2, 8'h03, 4'h3);
    step();
    ch_valid = '0;
    wait_start();
    repeat (3) step();
    chk("t5_sbusy", 32'(sched_busy), 32'd1);
    chk("t5_pend", 32'(ch_ready), COAL ? 32'hF : 32'h9);
    rst = 1'b1;
    step();
    chk_reset_vals("t5");
    rst = 1'b0;
    t0 = st_cyc.size();
    repeat (40) step();
    chk("t5_no_start", 32'(st_cyc.size()), 32'(t0));

    // Three writes to ch0 while a ch1 frame is in flight.
    busy_len = 5;
    st_ch.delete();
    st_word.delete();
    wr(1, 8'h77, 4'h1);
    step();
    ch_valid = '0;
    wait_start();
    wr(0, 8'd10, 4'h2);
    step();
    chk("t6_rdy0", 32'(ch_ready[0]), 32'(COAL));
    wr(0, 8'd20, 4'h2);
    step();
    wr(0, 8'd30, 4'h2);
    step();
    ch_valid = '0;
    wait_idle();
    chk("t6_frames", 32'(st_ch.size()), 32'd2);
    if (st_ch.size() == 2) begin
      chk("t6_g0", 32'(st_ch[0]), 32'd1);
      chk("t6_g1", 32'(st_ch[1]), 32'd0);
      chk("t6_w1", 32'(st_word[1]), COAL ? 32'h01E2 : 32'h00A2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_dac_scheduler.md
Name: spi_dac_scheduler

Overview:
- Sequences DAC updates from NUM_CH independent requesters onto one shared SPI DAC serializer.
- Each requester posts a data/config pair per channel. Pending requests are picked round-robin, formatted into a 16-bit frame and launched with a one-cycle start pulse.
- Waits for the serializer's busy to rise and fall, then enforces a minimum chip-select-high gap before the next frame.
- Sits between control logic (PWM, waveform generators, host registers) and the SPI DAC serializer.

Parameters:
- NUM_CH, 4, number of requesters/channels (2..8).
- DATA_W, 8, DAC data width per request.
- CFG_W, 4, DAC config nibble width; DATA_W+CFG_W <= 16.
- GAP_CYC, 4, minimum idle clk cycles between the end of busy and the next start (>= 1).
- BUSY_TO, 16, clk cycles to wait for spi_busy to rise after spi_start before aborting the frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- ch_valid  in  NUM_CH  per-channel write request.
- ch_ready  out  NUM_CH  per-channel accept; a write occurs when valid&ready.
- ch_data  in  NUM_CH*DATA_W  packed data, channel i at [i*DATA_W +: DATA_W].
- ch_cfg  in  NUM_CH*CFG_W  packed config, channel i at [i*CFG_W +: CFG_W].
- spi_start  out  1  one-cycle launch pulse to the serializer.
- spi_word  out  16  frame, zero-extended {data,cfg}, stable from start until busy falls.
- spi_busy  in  1  serializer busy (chip select asserted).
- grant_ch  out  $clog2(NUM_CH)  channel of the frame in flight or last sent.
- sched_busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky, set when busy never rose; cleared only by rst.

Behaviour:
- Reset values: ch_ready all 1, spi_start 0, spi_word 0, grant_ch 0, sched_busy 0, timeout_err 0, all pending flags 0, RR pointer NUM_CH-1 (so ch0 wins first), FSM in IDLE.
- Per channel, a pending flag plus a data/cfg holding register.
  - Base behaviour: ch_ready[i] = !pending[i].
  - An accepted write sets pending and captures data/cfg in the same cycle.
- FSM states: IDLE, ARB, START, WAIT_HI, WAIT_LO, GAP.
- IDLE: if any pending, go to ARB next cycle.
- ARB: picks the first pending channel searching from pointer+1 upward with wrap. In the same cycle it:
  - loads spi_word;
  - sets grant_ch and the pointer to the winner;
  - clears pending[winner] (ready returns the following cycle);
  - goes to START.
- START: spi_start=1 for exactly one cycle, then WAIT_HI.
- WAIT_HI:
  - spi_busy=1 -> WAIT_LO.
  - After BUSY_TO cycles without busy: set timeout_err, go to GAP; the frame is dropped, not retried.
- WAIT_LO: spi_busy=0 -> GAP.
- GAP: counts GAP_CYC cycles, then IDLE.
- Latency: a write into an idle scheduler gives spi_start 3 cycles later (accept, IDLE->ARB, ARB->START).
- Back-to-back frame spacing after busy falls: GAP_CYC + 3 cycles.
- Fairness: with all channels continuously pending, the grant order is 0,1,..,NUM_CH-1,0.
- Simultaneous writes on several channels in one cycle are all accepted.
- A write on the channel being granted in ARB cannot occur in base mode, because ready is low while pending.
- rst mid-frame: returns to IDLE immediately, drops all pending and spi_start, and does not wait for busy. The serializer is reset by the same rst.
- spi_busy high while in IDLE, ARB or GAP is ignored. The scheduler does not start until it returns through GAP->IDLE.

Optional Feature:
- Macro: SPI_DAC_SCHED_COALESCE_EN.
- Defined:
  - ch_ready is constantly 1.
  - A write to a pending channel overwrites its held data/cfg; only the newest value is sent.
  - A write in the same cycle as ARB granting that channel: the frame carries the old value, and pending stays set with the new value.
- Undefined: base behaviour above; a pending channel back-pressures its requester.

Decomposition:
- Package spi_dac_pkg holds:
  - the FSM state enum;
  - FRAME_W=16;
  - the frame-packing function {zero pad, data, cfg}, shared with the serializer.
- Natural sub-module: rr_arbiter, parameterized NUM_CH.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded index, any-request.
  - Purely combinational; the pointer register lives in the scheduler.

Test Plan:
- Single write ch2 data=120 cfg=4'hC at idle:
  - spi_start 3 cycles later, spi_word=16'h078C, grant_ch=2.
  - ch_ready[2] low until the cycle after ARB.
- All 4 channels written in one cycle; model busy 1 cycle after start for 20 cycles:
  - grants 0,1,2,3 in order;
  - start-to-start spacing = 20+1+GAP_CYC+3 cycles.
- Continuous requests on ch1 and ch3 for 6 frames -> grants alternate 1,3,1,3,1,3.
- spi_busy held 0 after start:
  - timeout_err set BUSY_TO cycles after the start pulse;
  - FSM passes through GAP to IDLE;
  - the next pending request is still served.
- rst asserted while in WAIT_LO with 2 channels pending -> next cycle all outputs at reset values and no further spi_start.
- COALESCE_EN: three writes to ch0 (data 10, 20, 30) while a frame for ch1 is in flight -> ch0 frame carries data=30, and only one frame is sent for ch0.
